sprite_line_scheduler: RTL and testbench
========================================

// Module: sprite_line_scheduler
// PURPOSE
//  Per-scanline sprite scheduler between the Avalon sprite-descriptor writes and the sprite ROM fetch/render path.
//  On each line_start it scans all sprite descriptors and picks those intersecting the next scanline.
//  Selected slots go out one at a time over a valid/ready handshake; the fetch unit turns each into ROM addresses.
// PARAMETERS
//  NUM_SPRITES   20  descriptor count; Avalon address range 0..NUM_SPRITES-1
//  MAX_PER_LINE   8  max slots issued per scanline; further hits set line_overflow
//  SPRITE_DIM    32  sprite height/width in pixels (32x32 = 1024-word ROM)
// PORTS
//  clk            in   1   system clock (50 MHz domain)
//  reset          in   1   synchronous, active-high
//  wr_en          in   1   descriptor write strobe (write && chipselect)
//  wr_addr        in   5   descriptor index
//  wr_data        in   32  descriptor: [31]=en [30:27]=rom_sel [26:17]=x [16:7]=y [6:0]=rsvd
//  frame_start    in   1   1-cycle pulse at start of vertical blank
//  line_start     in   1   1-cycle pulse at start of hblank; begins scan for next_line
//  next_line      in   10  scanline being prepared; sampled on line_start
//  slot_valid     out  1   slot presented
//  slot_ready     in   1   fetch unit accepts slot
//  slot_idx       out  5   descriptor index of slot
//  slot_rom_sel   out  4   ROM select (ship, pig, bee, cow, digits, bullet...)
//  slot_x         out  10  sprite x origin
//  slot_row       out  5   row within sprite = next_line - y
//  line_done      out  1   1-cycle pulse when the scan for this line completes
//  line_overflow  out  1   more than MAX_PER_LINE hits on the current line
//  line_late      out  1   sticky: line_start arrived before line_done; cleared on frame_start
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, descriptors=0 (all disabled).
//  Writes: wr_addr >= NUM_SPRITES ignored.
//  FSM IDLE -> SCAN on line_start.
//   line_start: latch next_line, set idx=0, set count=0, clear line_overflow.
//  SCAN: evaluate one descriptor per cycle.
//   hit = en && next_line >= y && next_line < y+SPRITE_DIM (11-bit compare; no 10-bit wrap).
//   hit with count<MAX_PER_LINE: register slot fields -> ISSUE.
//   hit with count==MAX_PER_LINE: set line_overflow -> DONE.
//   miss with idx==NUM_SPRITES-1 -> DONE; miss otherwise: idx++.
//  ISSUE: slot_valid=1, fields held stable until slot_ready.
//   On valid&&ready: count++.
//   idx==NUM_SPRITES-1 -> DONE; otherwise idx++ -> SCAN.
//   No combinational ready->valid path.
//  DONE: line_done=1 for one cycle -> IDLE.
//  Latency: line_start at cycle N; idx0 evaluated N+1; first slot_valid N+2 if idx0 hits.
//   Worst case (no hits): line_done at N+NUM_SPRITES+1.
//  line_start in SCAN/ISSUE/DONE:
//   abort; drop slot_valid next cycle; set line_late; restart at idx0 with new next_line.
//   A pending slot is discarded unacknowledged; line_done is not pulsed for the aborted line.
//  line_start and valid&&ready in the same cycle: handshake completes, then the restart applies.
//  frame_start and line_start in the same cycle: line_late is cleared, then set if the abort applies.
//  Priority is fixed by descriptor index (lower index issues first).
//  Reset mid-scan: immediate IDLE, slot_valid=0 next cycle.
// CONFIGURATION
//  SPRITE_SHADOW_COMMIT_EN defined:
//   writes go to a shadow bank; the whole shadow copies to the active bank on frame_start.
//   Scans read the active bank only, so there is no mid-frame tearing.
//   A write coinciding with frame_start lands in shadow and commits at the next frame_start.
//  Undefined: single bank; a write takes effect the next cycle, including mid-scan.
// STRUCTURE
//  sprite_pkg:
//   sprite_desc_t packed struct (en, rom_sel, x, y, rsvd)
//   NUM_SPRITES_C, SPRITE_DIM_C, coordinate width constants
//   sched_state_t enum {IDLE, SCAN, ISSUE, DONE}
//  Sub-module sprite_desc_bank: register file, write decode, optional shadow/commit;
//   async read port by idx.
//  Top: FSM, hit compare, slot registers, counters.
// TESTING
//  1 Descriptor 3 = en, rom_sel=2, x=100, y=50; line_start with next_line=60
//    -> one slot: idx=3, rom_sel=2, x=100, row=10; line_done follows.
//  2 Descriptors 0..9 all cover line 40; slot_ready=1
//    -> slots idx 0..7 in order, line_overflow=1, line_done.
//  3 slot_ready held low 5 cycles
//    -> slot_valid and fields stable all 5 cycles; exactly one transfer counted.
//  4 Boundaries, y=50: next_line=81 -> row=31; next_line=82 or 49 -> no slot.
//    y=1000, next_line=5 -> no slot.
//  5 line_start again 4 cycles after the first, mid-ISSUE
//    -> slot dropped, line_late=1, rescan with the new line; frame_start clears line_late.
//  6 With SPRITE_SHADOW_COMMIT_EN: write desc 0 y=10 mid-frame, scan line 12 -> no slot;
//    after frame_start -> slot row=2. Without the macro -> slot row=2 immediately.

Source files
------------

// File: rtl/sprite_line_scheduler_pkg.sv
// sprite_line_scheduler_pkg: shared sizes, descriptor layout and FSM states for the sprite line scheduler.
package sprite_line_scheduler_pkg;
    localparam int NUM_SPRITES_C  = 20;
    localparam int MAX_PER_LINE_C = 8;
    localparam int SPRITE_DIM_C   = 32;
    localparam int IDX_W   = 5;
    localparam int COORD_W = 10;
    localparam int ROW_W   = 5;
    localparam int ROM_W   = 4;
    localparam int CNT_W   = 4;
    localparam logic [IDX_W-1:0]   LAST_IDX_C = IDX_W'(NUM_SPRITES_C - 1);
    localparam logic [CNT_W-1:0]   MAX_CNT_C  = CNT_W'(MAX_PER_LINE_C);
    localparam logic [COORD_W:0]   DIM_EXT_C  = (COORD_W + 1)'(SPRITE_DIM_C);
    typedef struct packed {
        logic               en;
        logic [ROM_W-1:0]   rom_sel;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [6:0]         rsvd;
    } sprite_desc_t;
    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, DONE} sched_state_t;
endpackage

// File: rtl/sprite_line_scheduler_if.sv
// sprite_line_scheduler_if: slot handshake from the scheduler (master) to the ROM fetch unit (slave).
interface sprite_line_scheduler_if;
    import sprite_line_scheduler_pkg::*;
    logic               valid;
    logic               ready;
    logic [IDX_W-1:0]   idx;
    logic [ROM_W-1:0]   rom_sel;
    logic [COORD_W-1:0] x;
    logic [ROW_W-1:0]   row;
    modport master(output valid, idx, rom_sel, x, row, input ready);
    modport slave(input valid, idx, rom_sel, x, row, output ready);
endinterface

// File: rtl/sprite_line_scheduler_desc_bank.sv
// sprite_line_scheduler_desc_bank: descriptor register file with async read by index.
// SPRITE_SHADOW_COMMIT_EN: writes land in a shadow bank copied to the active bank on frame_start.
module sprite_line_scheduler_desc_bank
    import sprite_line_scheduler_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_addr,
    input  logic [31:0]      i_wr_data,
    input  logic             i_frame_start,
    input  logic [IDX_W-1:0] i_rd_idx,
    output sprite_desc_t     o_rd_desc
);
    sprite_desc_t r_active [NUM_SPRITES_C];
    logic         w_wr_ok;
    assign w_wr_ok = i_wr_en && i_wr_addr <= LAST_IDX_C;
`ifdef SPRITE_SHADOW_COMMIT_EN
    sprite_desc_t r_shadow [NUM_SPRITES_C];
    // The commit copies the shadow as it stood before this cycle's write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES_C; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            if (w_wr_ok) r_shadow[i_wr_addr] <= i_wr_data;
            if (i_frame_start) r_active <= r_shadow;
        end
    end
`else
    logic w_unused_frame;
    assign w_unused_frame = i_frame_start;
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES_C; i++) r_active[i] <= '0;
        end else if (w_wr_ok) begin
            r_active[i_wr_addr] <= i_wr_data;
        end
    end
`endif
    assign o_rd_desc = r_active[i_rd_idx];
endmodule

// File: rtl/sprite_line_scheduler.sv
// sprite_line_scheduler: scans all sprite descriptors per scanline and issues the hits, lowest index first.
// Optional SPRITE_SHADOW_COMMIT_EN selects frame-synchronous descriptor commit in the bank.
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_addr,
    input  logic [31:0]            i_wr_data,
    input  logic                   i_frame_start,
    input  logic                   i_line_start,
    input  logic [COORD_W-1:0]     i_next_line,
    sprite_line_scheduler_if.master slot,
    output logic                   o_line_done,
    output logic                   o_line_overflow,
    output logic                   o_line_late
);
    sched_state_t       r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [CNT_W-1:0]   r_count, w_count_nxt;
    logic [COORD_W-1:0] r_line;
    logic               r_overflow, w_overflow_nxt, r_late;
    logic [IDX_W-1:0]   r_slot_idx;
    logic [ROM_W-1:0]   r_slot_rom;
    logic [COORD_W-1:0] r_slot_x;
    logic [ROW_W-1:0]   r_slot_row;
    sprite_desc_t       w_desc;
    logic [COORD_W:0]   w_line_ext, w_y_ext;
    logic [ROW_W-1:0]   w_row;
    logic               w_hit, w_xfer, w_last, w_load, w_unused_rsvd;

    sprite_line_scheduler_desc_bank u_bank (
        .clk          (clk),
        .reset        (reset),
        .i_wr_en      (i_wr_en),
        .i_wr_addr    (i_wr_addr),
        .i_wr_data    (i_wr_data),
        .i_frame_start(i_frame_start),
        .i_rd_idx     (r_idx),
        .o_rd_desc    (w_desc)
    );

    // Widened compare so sprites near the bottom edge do not wrap around to line 0.
    assign w_line_ext    = {1'b0, r_line};
    assign w_y_ext       = {1'b0, w_desc.y};
    assign w_hit         = w_desc.en && w_line_ext >= w_y_ext && w_line_ext < w_y_ext + DIM_EXT_C;
    assign w_row         = ROW_W'(r_line - w_desc.y);
    assign w_last        = r_idx == LAST_IDX_C;
    assign w_xfer        = slot.valid && slot.ready;
    assign w_unused_rsvd = ^w_desc.rsvd;

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow;
        w_load         = 1'b0;
        if (i_line_start) begin
            w_state_nxt    = SCAN;
            w_idx_nxt      = '0;
            w_count_nxt    = '0;
            w_overflow_nxt = 1'b0;
        end else begin
            case (r_state)
                IDLE: ;
                SCAN: begin
                    if (w_hit && r_count == MAX_CNT_C) begin
                        w_overflow_nxt = 1'b1;
                        w_state_nxt    = DONE;
                    end else if (w_hit) begin
                        w_load      = 1'b1;
                        w_state_nxt = ISSUE;
                    end else begin
                        w_state_nxt = w_last ? DONE : SCAN;
                        w_idx_nxt   = w_last ? r_idx : r_idx + 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_xfer) begin
                        w_count_nxt = r_count + 1'b1;
                        w_state_nxt = w_last ? DONE : SCAN;
                        w_idx_nxt   = w_last ? r_idx : r_idx + 1'b1;
                    end
                end
                DONE: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_count    <= '0;
            r_line     <= '0;
            r_overflow <= 1'b0;
            r_late     <= 1'b0;
            r_slot_idx <= '0;
            r_slot_rom <= '0;
            r_slot_x   <= '0;
            r_slot_row <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
            r_late     <= (i_line_start && r_state != IDLE) || (r_late && !i_frame_start);
            if (i_line_start) r_line <= i_next_line;
            if (w_load) begin
                r_slot_idx <= r_idx;
                r_slot_rom <= w_desc.rom_sel;
                r_slot_x   <= w_desc.x;
                r_slot_row <= w_row;
            end
        end
    end

    assign slot.valid      = r_state == ISSUE;
    assign slot.idx        = r_slot_idx;
    assign slot.rom_sel    = r_slot_rom;
    assign slot.x          = r_slot_x;
    assign slot.row        = r_slot_row;
    assign o_line_done     = r_state == DONE;
    assign o_line_overflow = r_overflow;
    assign o_line_late     = r_late;
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// tb_sprite_line_scheduler: scenario tasks plus randomized scans checked against a descriptor-list model.
module tb_sprite_line_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        i_wr_en;
    logic [4:0]  i_wr_addr;
    logic [31:0] i_wr_data;
    logic        i_frame_start, i_line_start;
    logic [9:0]  i_next_line;
    logic        o_line_done, o_line_overflow, o_line_late;
    int          checks = 0, errors = 0;
    logic [31:0] m_act [20];
    logic [31:0] m_sh  [20];
    logic [23:0] got_q [$];
    logic [23:0] exp_q [$];
    bit          got_done, got_ovf, exp_ovf;

    sprite_line_scheduler_if slot();

    sprite_line_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .i_wr_en        (i_wr_en),
        .i_wr_addr      (i_wr_addr),
        .i_wr_data      (i_wr_data),
        .i_frame_start  (i_frame_start),
        .i_line_start   (i_line_start),
        .i_next_line    (i_next_line),
        .slot           (slot),
        .o_line_done    (o_line_done),
        .o_line_overflow(o_line_overflow),
        .o_line_late    (o_line_late)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input bit en, input int rom, input int x, input int y);
        return {en, 4'(rom), 10'(x), 10'(y), 7'($urandom_range(127))};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        i_wr_en = 1'b0; i_frame_start = 1'b0; i_line_start = 1'b0; slot.ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            m_act[i] = '0;
            m_sh[i]  = '0;
        end
    endtask

    task automatic write_desc(input int a, input logic [31:0] d, input bit fs);
        i_wr_en = 1'b1; i_wr_addr = 5'(a); i_wr_data = d; i_frame_start = fs;
        tick();
        i_wr_en = 1'b0; i_frame_start = 1'b0;
`ifdef SPRITE_SHADOW_COMMIT_EN
        if (fs) m_act = m_sh;
        if (a < 20) m_sh[a] = d;
`else
        if (a < 20) m_act[a] = d;
`endif
    endtask

    task automatic frame_pulse();
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
`ifdef SPRITE_SHADOW_COMMIT_EN
        m_act = m_sh;
`endif
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            if (o_line_done) seen = 1'b1;
            else tick();
        end
        tick();
    endtask

    // Drives one scanline and records every accepted slot as {idx, rom_sel, x, row}.
    task automatic run_line(input logic [9:0] line, input int ready_pct);
        got_q.delete();
        got_done = 1'b0;
        got_ovf  = 1'b0;
        i_next_line = line; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (o_line_done) begin
                got_done = 1'b1;
                got_ovf  = o_line_overflow;
                break;
            end
            slot.ready = $urandom_range(99) < ready_pct;
            if (slot.valid && slot.ready) got_q.push_back({slot.idx, slot.rom_sel, slot.x, slot.row});
            tick();
        end
        slot.ready = 1'b0;
        tick();
    endtask

    // Reference: every enabled descriptor covering the line, in index order, first eight issued.
    function automatic void model_line(input logic [9:0] line);
        int n, y, ln;
        n = 0;
        ln = int'(line);
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < 20; i++) begin
            y = int'(m_act[i][16:7]);
            if (m_act[i][31] && ln >= y && ln < y + 32) begin
                if (n < 8) exp_q.push_back({5'(i), m_act[i][30:27], m_act[i][26:17], 5'(ln - y)});
                else exp_ovf = 1'b1;
                n++;
            end
        end
    endfunction

    function automatic int q_diff();
        for (int i = 0; i < 64; i++) begin
            if (i >= got_q.size() && i >= exp_q.size()) return -1;
            if (i >= got_q.size() || i >= exp_q.size() || got_q[i] !== exp_q[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [23:0] qat(input bit from_got, input int k);
        if (from_got) return k < got_q.size() ? got_q[k] : 'x;
        return k < exp_q.size() ? exp_q[k] : 'x;
    endfunction

    task automatic test_reset();
        int n;
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({slot.valid, o_line_done, o_line_overflow, o_line_late, slot.idx, slot.rom_sel, slot.x, slot.row} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b d=%b o=%b l=%b idx=%0d rom=%0d x=%0d row=%0d, want all 0",
                     slot.valid, o_line_done, o_line_overflow, o_line_late, slot.idx, slot.rom_sel, slot.x, slot.row);
        end
        do_reset();
        i_next_line = 10'd5; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        n = 1;
        while (!o_line_done && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 21) begin
            errors++;
            $display("FAIL empty_scan_latency: line_done after %0d cycles, want 21", n);
        end
        tick();
    endtask

    task automatic test_single();
        do_reset();
        write_desc(3, mk(1, 2, 100, 50), 1'b0);
        run_line(10'd60, 100);
        model_line(10'd60);
        checks++;
        if ((got_q.size() == 1 ? got_q[0] : 24'hx) !== {5'd3, 4'd2, 10'd100, 5'd10} || !got_done) begin
            errors++;
            $display("FAIL single_slot: got n=%0d slot=%h done=%b, want n=1 slot=%h done=1",
                     got_q.size(), qat(1, 0), got_done, {5'd3, 4'd2, 10'd100, 5'd10});
        end
        checks++;
        if (got_ovf !== 1'b0) begin
            errors++;
            $display("FAIL single_overflow: got %b want 0", got_ovf);
        end
    endtask

    task automatic test_overflow();
        int k;
        bit ordered;
        do_reset();
        for (int i = 0; i < 10; i++) write_desc(i, mk(1, $urandom_range(15), $urandom_range(1023), 40 - $urandom_range(31)), 1'b0);
        run_line(10'd40, 100);
        model_line(10'd40);
        ordered = got_q.size() == 8;
        for (int i = 0; i < got_q.size() && i < 8; i++) if (got_q[i][23:19] !== 5'(i)) ordered = 1'b0;
        checks++;
        if (!ordered) begin
            errors++;
            $display("FAIL overflow_order: got n=%0d first=%h, want idx 0..7", got_q.size(), qat(1, 0));
        end
        checks++;
        if ({got_done, got_ovf} !== 2'b11) begin
            errors++;
            $display("FAIL overflow_flags: got done=%b ovf=%b, want 1 1", got_done, got_ovf);
        end
        k = q_diff();
        checks++;
        if (k !== -1) begin
            errors++;
            $display("FAIL overflow_fields: slot %0d got %h want %h", k, qat(1, k), qat(0, k));
        end
    endtask

    task automatic test_stall();
        int n, xfers;
        logic [23:0] held;
        do_reset();
        write_desc(0, mk(1, 7, 321, 100), 1'b0);
        i_next_line = 10'd110; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        n = 1;
        while (!slot.valid && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL first_valid_latency: got %0d cycles want 2", n);
        end
        held = {slot.idx, slot.rom_sel, slot.x, slot.row};
        checks++;
        if (held !== {5'd0, 4'd7, 10'd321, 5'd10}) begin
            errors++;
            $display("FAIL stall_fields: got %h want %h", held, {5'd0, 4'd7, 10'd321, 5'd10});
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (slot.valid !== 1'b1 || {slot.idx, slot.rom_sel, slot.x, slot.row} !== held) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: got v=%b %h want v=1 %h", c,
                         slot.valid, {slot.idx, slot.rom_sel, slot.x, slot.row}, held);
            end
            tick();
        end
        xfers = 0;
        slot.ready = 1'b1;
        for (int c = 0; c < 60 && !o_line_done; c++) begin
            if (slot.valid) xfers++;
            tick();
        end
        slot.ready = 1'b0;
        checks++;
        if (xfers !== 1 || o_line_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_transfer: got xfers=%0d done=%b want 1 1", xfers, o_line_done);
        end
        tick();
    endtask

    task automatic test_boundaries();
        int k;
        int lines [6] = '{81, 82, 49, 50, 5, 1023};
        do_reset();
        write_desc(0, mk(1, 3, 7, 50), 1'b0);
        write_desc(1, mk(1, 4, 9, 1000), 1'b0);
        run_line(10'd81, 100);
        checks++;
        if ((got_q.size() == 1 ? got_q[0] : 24'hx) !== {5'd0, 4'd3, 10'd7, 5'd31}) begin
            errors++;
            $display("FAIL boundary_row31: got n=%0d %h want %h", got_q.size(), qat(1, 0), {5'd0, 4'd3, 10'd7, 5'd31});
        end
        foreach (lines[j]) begin
            run_line(10'(lines[j]), 70);
            model_line(10'(lines[j]));
            k = q_diff();
            checks++;
            if (k !== -1 || !got_done) begin
                errors++;
                $display("FAIL boundary line=%0d: slot %0d got %h (n=%0d) want %h (n=%0d) done=%b",
                         lines[j], k, qat(1, k), got_q.size(), qat(0, k), exp_q.size(), got_done);
            end
        end
    endtask

    task automatic test_abort();
        bit seen;
        do_reset();
        write_desc(0, mk(1, 1, 5, 0), 1'b0);
        i_next_line = 10'd10; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        tick();
        checks++;
        if (slot.valid !== 1'b1 || slot.row !== 5'd10) begin
            errors++;
            $display("FAIL abort_pre: got v=%b row=%0d want v=1 row=10", slot.valid, slot.row);
        end
        tick(); tick();
        i_next_line = 10'd20; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        checks++;
        if ({slot.valid, o_line_late, o_line_done} !== 3'b010) begin
            errors++;
            $display("FAIL abort_drop: got valid/late/done=%b want 010", {slot.valid, o_line_late, o_line_done});
        end
        tick();
        checks++;
        if (slot.valid !== 1'b1 || slot.row !== 5'd20) begin
            errors++;
            $display("FAIL abort_rescan: got v=%b row=%0d want v=1 row=20", slot.valid, slot.row);
        end
        slot.ready = 1'b1;
        tick();
        slot.ready = 1'b0;
        wait_done(seen);
        checks++;
        if (!seen || o_line_late !== 1'b1) begin
            errors++;
            $display("FAIL abort_finish: got done=%b late=%b want 1 1", seen, o_line_late);
        end
        frame_pulse();
        checks++;
        if (o_line_late !== 1'b0) begin
            errors++;
            $display("FAIL late_clear: got %b want 0", o_line_late);
        end
        i_next_line = 10'd300; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        checks++;
        if (o_line_late !== 1'b0) begin
            errors++;
            $display("FAIL late_from_idle: got %b want 0", o_line_late);
        end
        i_frame_start = 1'b1; i_line_start = 1'b1;
        tick();
        i_frame_start = 1'b0; i_line_start = 1'b0;
        checks++;
        if (o_line_late !== 1'b1) begin
            errors++;
            $display("FAIL late_frame_and_line: got %b want 1", o_line_late);
        end
        wait_done(seen);
        i_next_line = 10'd10; i_line_start = 1'b1;
        tick();
        i_line_start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({slot.valid, o_line_done, o_line_late} !== 3'b000) begin
            errors++;
            $display("FAIL reset_midscan: got valid/done/late=%b want 000", {slot.valid, o_line_done, o_line_late});
        end
    endtask

    task automatic test_commit();
        int k;
        do_reset();
        write_desc(0, mk(1, 5, 200, 10), 1'b0);
        run_line(10'd12, 100);
        model_line(10'd12);
`ifdef SPRITE_SHADOW_COMMIT_EN
        checks++;
        if (got_q.size() !== 0) begin
            errors++;
            $display("FAIL commit_before_frame: got n=%0d want 0", got_q.size());
        end
        frame_pulse();
        run_line(10'd12, 100);
        model_line(10'd12);
`endif
        checks++;
        if ((got_q.size() == 1 ? got_q[0] : 24'hx) !== {5'd0, 4'd5, 10'd200, 5'd2}) begin
            errors++;
            $display("FAIL commit_slot: got n=%0d %h want %h", got_q.size(), qat(1, 0), {5'd0, 4'd5, 10'd200, 5'd2});
        end
        write_desc(0, mk(0, 5, 200, 10), 1'b1);
        run_line(10'd12, 100);
        model_line(10'd12);
        k = q_diff();
        checks++;
        if (k !== -1) begin
            errors++;
            $display("FAIL commit_write_at_frame: slot %0d got %h want %h", k, qat(1, k), qat(0, k));
        end
    endtask

    task automatic test_random();
        int k;
        logic [9:0] line;
        do_reset();
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 12; w++)
                write_desc($urandom_range(31), mk($urandom_range(3) != 0, $urandom_range(15), $urandom_range(1023),
                           $urandom_range(60)), $urandom_range(9) == 0);
            frame_pulse();
            for (int l = 0; l < 5; l++) begin
                line = 10'($urandom_range(100));
                run_line(line, 50);
                model_line(line);
                k = q_diff();
                checks++;
                if (k !== -1 || got_ovf !== exp_ovf || !got_done) begin
                    errors++;
                    $display("FAIL random line=%0d: slot %0d got %h (n=%0d) want %h (n=%0d) ovf=%b/%b done=%b",
                             line, k, qat(1, k), got_q.size(), qat(0, k), exp_q.size(), got_ovf, exp_ovf, got_done);
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        i_wr_en = 1'b0; i_wr_addr = '0; i_wr_data = '0;
        i_frame_start = 1'b0; i_line_start = 1'b0; i_next_line = '0;
        slot.ready = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_stall();
        test_boundaries();
        test_abort();
        test_commit();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end
endmodule
